commit_update_arbiter: RTL and testbench



---
 rtl/dice_commit_pkg.sv | 23 ++
 rtl/commit_update_arbiter_rr_priority_picker.sv | 33 +++
 rtl/commit_update_arbiter.sv | 159 +++++++++++++++
 tb/tb_commit_update_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dice_commit_pkg.sv
// dice_commit_pkg: types and constants for pending-count updates to the
// block commit table. Shared by the commit table, commit_update_arbiter and
// the LSU return paths.
//   e_block_id_t      - e-block table index
//   commit_upd_req_t  - one completion update {e_block_id, is_write, count}
//   MAX_REDUCE_COUNT  - largest amount one update may retire
package dice_commit_pkg;

    localparam int unsigned CMT_MAX_NUM_CTA = 4;
    localparam int unsigned CMT_MAX_EBLOCK  = CMT_MAX_NUM_CTA + 4;
    localparam int unsigned CMT_EB_W        = $clog2(CMT_MAX_EBLOCK);

    typedef logic [CMT_EB_W-1:0] e_block_id_t;

    typedef struct packed {
        e_block_id_t e_block_id;
        logic        is_write;
        logic [3:0]  count;
    } commit_upd_req_t;

    localparam logic [3:0] MAX_REDUCE_COUNT = 4'd8;

endpackage

// File: rtl/commit_update_arbiter_rr_priority_picker.sv
// rr_priority_picker: rotating find-first. Scans req starting at index base,
// wrapping modulo N, and reports the first set bit.
//   req          in  N      candidate vector
//   base         in  IDX_W  scan start index
//   grant_onehot out N      one-hot of the first set bit (0 if none)
//   grant_idx    out IDX_W  index of the first set bit (0 if none)
//   found        out 1      any bit of req set
module rr_priority_picker #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] base,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             found
);

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            automatic int unsigned k = (32'(base) + off) % N;
            if (!found && req[k]) begin
                found           = 1'b1;
                grant_onehot[k] = 1'b1;
                grant_idx       = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/commit_update_arbiter.sv
// commit_update_arbiter: shares the commit table's single pending-count
// update port among NUM_REQ completion sources. Each cycle a round-robin
// winner is chosen; other requesters with the same {e_block_id, is_write}
// key are greedily merged while the total stays <= MAX_REDUCE_COUNT. The
// merged update is registered onto upd_* (one cycle latency, one update per
// cycle, no backpressure from the table).
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-requester handshake (ready is combinational)
//   req_e_block_id    requester i at [i*EB_W +: EB_W]
//   req_is_write      0 = read completion, 1 = write completion
//   req_count         requester i at [i*4 +: 4], legal 1..8
//   upd_*             registered update to the commit table
//   stat_merge_cnt    saturating count of cycles with >=2 accepted requests
//   busy              any request pending or update in flight
module commit_update_arbiter
    import dice_commit_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MAX_NUM_CTA = 4,
    parameter int unsigned MAX_EBLOCK  = MAX_NUM_CTA + 4,
    localparam int unsigned EB_W       = $clog2(MAX_EBLOCK)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*EB_W-1:0] req_e_block_id,
    input  logic [NUM_REQ-1:0]      req_is_write,
    input  logic [NUM_REQ*4-1:0]    req_count,
    output logic                    upd_valid,
    output logic [EB_W-1:0]         upd_e_block_id,
    output logic                    upd_is_write,
    output logic [3:0]              upd_reduce_count,
    output logic [15:0]             stat_merge_cnt,
    output logic                    busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               upd_valid_q, upd_valid_d;
    logic [EB_W-1:0]    upd_e_block_id_q, upd_e_block_id_d;
    logic               upd_is_write_q, upd_is_write_d;
    logic [3:0]         upd_reduce_count_q, upd_reduce_count_d;
    logic [15:0]        stat_merge_cnt_q, stat_merge_cnt_d;

    logic [NUM_REQ-1:0] win_onehot;
    logic [PTR_W-1:0]   win_idx;
    logic               win_found;

    logic [EB_W-1:0]    win_eb;
    logic               win_wr;
    logic [4:0]         sum;
    logic [NUM_REQ-1:0] grant;
    logic               merged;

    rr_priority_picker #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_win_pick (
        .req          (req_valid),
        .base         (rr_ptr_q),
        .grant_onehot (win_onehot),
        .grant_idx    (win_idx),
        .found        (win_found)
    );

    // Winner fields, then a greedy rotating scan after the winner: a
    // mismatched or non-fitting requester is skipped, later ones may still join.
    always_comb begin
        win_eb = '0;
        win_wr = 1'b0;
        sum    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                win_eb = req_e_block_id[i*EB_W +: EB_W];
                win_wr = req_is_write[i];
                sum    = {1'b0, req_count[i*4 +: 4]};
            end
        end
        grant = win_onehot;
        for (int unsigned off = 1; off < NUM_REQ; off++) begin
            automatic int unsigned j    = (32'(win_idx) + off) % NUM_REQ;
            automatic logic [4:0]  cand = {1'b0, req_count[j*4 +: 4]};
            if (win_found && req_valid[j]
                && (req_e_block_id[j*EB_W +: EB_W] == win_eb)
                && (req_is_write[j] == win_wr)
                && ((sum + cand) <= {1'b0, MAX_REDUCE_COUNT})) begin
                grant[j] = 1'b1;
                sum      = sum + cand;
            end
        end
        merged = |(grant & ~win_onehot);
    end

    always_comb begin
        upd_valid_d        = win_found;
        upd_e_block_id_d   = upd_e_block_id_q;
        upd_is_write_d     = upd_is_write_q;
        upd_reduce_count_d = upd_reduce_count_q;
        rr_ptr_d           = rr_ptr_q;
        stat_merge_cnt_d   = stat_merge_cnt_q;
        if (win_found) begin
            upd_e_block_id_d   = win_eb;
            upd_is_write_d     = win_wr;
            upd_reduce_count_d = sum[3:0];
            rr_ptr_d           = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                  : win_idx + PTR_W'(1);
        end
        if (merged && (stat_merge_cnt_q != '1)) begin
            stat_merge_cnt_d = stat_merge_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q           <= '0;
            upd_valid_q        <= 1'b0;
            upd_e_block_id_q   <= '0;
            upd_is_write_q     <= 1'b0;
            upd_reduce_count_q <= '0;
            stat_merge_cnt_q   <= '0;
        end else begin
            rr_ptr_q           <= rr_ptr_d;
            upd_valid_q        <= upd_valid_d;
            upd_e_block_id_q   <= upd_e_block_id_d;
            upd_is_write_q     <= upd_is_write_d;
            upd_reduce_count_q <= upd_reduce_count_d;
            stat_merge_cnt_q   <= stat_merge_cnt_d;
        end
    end

    assign req_ready        = grant;
    assign upd_valid        = upd_valid_q;
    assign upd_e_block_id   = upd_e_block_id_q;
    assign upd_is_write     = upd_is_write_q;
    assign upd_reduce_count = upd_reduce_count_q;
    assign stat_merge_cnt   = stat_merge_cnt_q;
    assign busy             = (|req_valid) | upd_valid_q;

`ifndef SYNTHESIS
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_chk
        a_count_legal: assert property (@(posedge clk) disable iff (!rst_n)
            req_valid[gi] |-> (req_count[gi*4 +: 4] >= 4'd1)
                           && (req_count[gi*4 +: 4] <= MAX_REDUCE_COUNT));
        a_eb_legal: assert property (@(posedge clk) disable iff (!rst_n)
            req_valid[gi] |-> (32'(req_e_block_id[gi*EB_W +: EB_W]) < MAX_EBLOCK));
        a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
            (req_valid[gi] && !req_ready[gi]) |=>
                ($stable(req_e_block_id[gi*EB_W +: EB_W])
                 && $stable(req_is_write[gi])
                 && $stable(req_count[gi*4 +: 4])));
    end

    a_upd_count_cap: assert property (@(posedge clk) disable iff (!rst_n)
        upd_valid |-> (upd_reduce_count <= MAX_REDUCE_COUNT));
`endif

endmodule

// File: tb/tb_commit_update_arbiter.sv
module tb_commit_update_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] req_e_block_id;
    logic [3:0]  req_is_write;
    logic [15:0] req_count;
    logic        upd_valid;
    logic [2:0]  upd_e_block_id;
    logic        upd_is_write;
    logic [3:0]  upd_reduce_count;
    logic [15:0] stat_merge_cnt;
    logic        busy;

    always #5 clk = ~clk;

    commit_update_arbiter #(
        .NUM_REQ     (4),
        .MAX_NUM_CTA (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_e_block_id   (req_e_block_id),
        .req_is_write     (req_is_write),
        .req_count        (req_count),
        .upd_valid        (upd_valid),
        .upd_e_block_id   (upd_e_block_id),
        .upd_is_write     (upd_is_write),
        .upd_reduce_count (upd_reduce_count),
        .stat_merge_cnt   (stat_merge_cnt),
        .busy             (busy)
    );

    typedef struct packed {
        logic       uv;
        logic [2:0] eb;
        logic       wr;
        logic [3:0] cnt;
    } upd_t;

    typedef struct packed {
        logic [3:0]  v;
        logic [11:0] eb;
        logic [3:0]  wr;
        logic [15:0] cnt;
        logic [3:0]  rdy;
        logic [2:0]  xeb;
        logic        xwr;
        logic [3:0]  xcnt;
    } vec_t;

    upd_t sb_q[$];
    upd_t last_upd;
    vec_t tbl[11];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   stat_exp  = 0;

    function automatic logic [11:0] pe(input int unsigned e3, e2, e1, e0);
        return {3'(e3), 3'(e2), 3'(e1), 3'(e0)};
    endfunction

    function automatic logic [15:0] pc(input int unsigned c3, c2, c1, c0);
        return {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one cycle of requests, check same-cycle ready, queue the expected
    // update, then after the edge pop and compare the registered update.
    task automatic apply(input string name, input logic [3:0] v, input logic [11:0] eb,
                         input logic [3:0] wr, input logic [15:0] cnt, input logic [3:0] rdy,
                         input logic [2:0] xeb, input logic xwr, input logic [3:0] xcnt);
        upd_t e, got;
        req_valid      = v;
        req_e_block_id = eb;
        req_is_write   = wr;
        req_count      = cnt;
        #3;
        chk({name, ".ready"}, 32'(req_ready), 32'(rdy));
        if (|rdy) begin
            e = {1'b1, xeb, xwr, xcnt};
            last_upd = e;
        end else begin
            e = {1'b0, last_upd.eb, last_upd.wr, last_upd.cnt};
        end
        sb_q.push_back(e);
        if ($countones(rdy) >= 2) stat_exp++;
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk({name, ".upd_valid"}, 32'(upd_valid), 32'(got.uv));
        chk({name, ".upd_eb"},    32'(upd_e_block_id), 32'(got.eb));
        chk({name, ".upd_wr"},    32'(upd_is_write), 32'(got.wr));
        chk({name, ".upd_cnt"},   32'(upd_reduce_count), 32'(got.cnt));
        chk({name, ".stat"},      32'(stat_merge_cnt), 32'(stat_exp));
        chk({name, ".busy"},      32'(busy), 32'((|v) | got.uv));
    endtask

    task automatic do_reset(input string name);
        rst_n          = 1'b0;
        req_valid      = '0;
        req_e_block_id = '0;
        req_is_write   = '0;
        req_count      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        last_upd = '0;
        stat_exp = 0;
        chk({name, ".upd_valid"}, 32'(upd_valid), 32'd0);
        chk({name, ".upd_eb"},    32'(upd_e_block_id), 32'd0);
        chk({name, ".upd_wr"},    32'(upd_is_write), 32'd0);
        chk({name, ".upd_cnt"},   32'(upd_reduce_count), 32'd0);
        chk({name, ".stat"},      32'(stat_merge_cnt), 32'd0);
        chk({name, ".busy"},      32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Expectations for the sequential table follow the round-robin pointer
        // from reset: 0 ->1 ->2 ->3 ->0 ->0 ->1 ->2 ->0 ->2 ->3 ->2.
        tbl[0]  = '{4'b0001, pe(0,0,0,3), 4'b0000, pc(0,0,0,5), 4'b0001, 3'd3, 1'b0, 4'd5};
        tbl[1]  = '{4'b0010, pe(0,0,4,0), 4'b0010, pc(0,0,1,0), 4'b0010, 3'd4, 1'b1, 4'd1};
        tbl[2]  = '{4'b0100, pe(0,5,0,0), 4'b0000, pc(0,8,0,0), 4'b0100, 3'd5, 1'b0, 4'd8};
        tbl[3]  = '{4'b1000, pe(7,0,0,0), 4'b1000, pc(2,0,0,0), 4'b1000, 3'd7, 1'b1, 4'd2};
        tbl[4]  = '{4'b0000, pe(0,0,0,0), 4'b0000, pc(0,0,0,0), 4'b0000, 3'd0, 1'b0, 4'd0};
        tbl[5]  = '{4'b0101, pe(0,2,0,2), 4'b0101, pc(0,4,0,3), 4'b0101, 3'd2, 1'b1, 4'd7};
        tbl[6]  = '{4'b1111, pe(6,6,6,6), 4'b0000, pc(2,2,2,2), 4'b1111, 3'd6, 1'b0, 4'd8};
        tbl[7]  = '{4'b1010, pe(0,0,0,0), 4'b1010, pc(1,0,8,0), 4'b1000, 3'd0, 1'b1, 4'd1};
        tbl[8]  = '{4'b0010, pe(0,0,0,0), 4'b0010, pc(0,0,8,0), 4'b0010, 3'd0, 1'b1, 4'd8};
        tbl[9]  = '{4'b0110, pe(0,1,1,0), 4'b0100, pc(0,1,1,0), 4'b0100, 3'd1, 1'b1, 4'd1};
        tbl[10] = '{4'b0010, pe(0,1,1,0), 4'b0100, pc(0,1,1,0), 4'b0010, 3'd1, 1'b0, 4'd1};

        rst_n          = 1'b0;
        req_valid      = '0;
        req_e_block_id = '0;
        req_is_write   = '0;
        req_count      = '0;
        last_upd       = '0;
        #2;
        chk("async_rst.upd_valid", 32'(upd_valid), 32'd0);
        do_reset("rst0");

        for (int i = 0; i < 11; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].v, tbl[i].eb, tbl[i].wr, tbl[i].cnt,
                  tbl[i].rdy, tbl[i].xeb, tbl[i].xwr, tbl[i].xcnt);
        end

        // Cap: req1 would overflow 8 so it is skipped; req3 still fits.
        do_reset("rst_cap");
        apply("cap0", 4'b1011, pe(2,0,2,2), 4'b0000, pc(2,0,3,6), 4'b1001, 3'd2, 1'b0, 4'd8);
        apply("cap1", 4'b0010, pe(2,0,2,2), 4'b0000, pc(2,0,3,6), 4'b0010, 3'd2, 1'b0, 4'd3);

        do_reset("rst_km");
        apply("km0", 4'b0011, pe(0,0,1,1), 4'b0010, pc(0,0,2,2), 4'b0001, 3'd1, 1'b0, 4'd2);
        apply("km1", 4'b0010, pe(0,0,1,1), 4'b0010, pc(0,0,2,2), 4'b0010, 3'd1, 1'b1, 4'd2);

        do_reset("rst_fair");
        for (int c = 0; c < 8; c++) begin
            automatic int unsigned w = 32'(c % 4);
            apply($sformatf("fair%0d", c), 4'b1111, pe(3,2,1,0), 4'b0000, pc(1,1,1,1),
                  4'(1 << w), 3'(w), 1'b0, 4'd1);
        end

        // Reset mid-flight: update registered and req1 pending when rst_n drops.
        do_reset("rst_rm");
        apply("rm_merge", 4'b0101, pe(0,2,0,2), 4'b0000, pc(0,1,0,1), 4'b0101, 3'd2, 1'b0, 4'd2);
        req_valid      = 4'b0010;
        req_e_block_id = pe(0,0,5,0);
        req_is_write   = 4'b0010;
        req_count      = pc(0,0,3,0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rm_async.upd_valid", 32'(upd_valid), 32'd0);
        chk("rm_async.stat",      32'(stat_merge_cnt), 32'd0);
        chk("rm_async.upd_cnt",   32'(upd_reduce_count), 32'd0);
        chk("rm_async.busy",      32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        last_upd = '0;
        stat_exp = 0;
        apply("rm_first", 4'b0010, pe(0,0,5,0), 4'b0010, pc(0,0,3,0), 4'b0010, 3'd5, 1'b1, 4'd3);
        apply("rm_idle", 4'b0000, pe(0,0,0,0), 4'b0000, pc(0,0,0,0), 4'b0000, 3'd0, 1'b0, 4'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
